// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin front end that time-shares one sequential
// multiplier (operands + start strobe in, product + done flag out) among
// NUM_REQ requesters. One transaction is in flight at a time:
// IDLE (accept) -> ISSUE (start strobe) -> WAIT (done edge or timeout) -> RESP.
module mul_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    output logic                       mul_in_valid,
    input  logic [2*WIDTH-1:0]         mul_result,
    input  logic                       mul_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last_grant, cur_idx, win_idx;
    logic            win_found;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [CW-1:0]   cnt;
    logic            done_q, done_edge, timeout_hit;
    logic [PW-1:0]   res_q;
    logic            err_q;

    // A stale high level from the previous operation must not count as done.
    assign done_edge   = mul_done & ~done_q;
    assign timeout_hit = (cnt + CW'(1)) == CW'(TIMEOUT_CYCLES);

    // Round-robin pick: lowest requester above last_grant wins, else wrap to lowest overall.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win_idx   = IW'(i);
                win_found = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (i > int'(last_grant))) begin
                win_idx = IW'(i);
            end
        end
    end

    // Operand mux for the current winner; only latched in the accept cycle.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic for the single-transaction sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_edge || timeout_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction without a response.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Datapath: operand latch, owner tracking, timeout count, result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IW'(NUM_REQ - 1);
            cur_idx    <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            cnt        <= '0;
            done_q     <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= mul_done;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        cur_idx <= win_idx;
                        mul_a   <= sel_a;
                        mul_b   <= sel_b;
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    if (done_edge) begin
                        res_q <= mul_result;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP: last_grant <= cur_idx;
                default: ;
            endcase
        end
    end

    // Accept and response strobes; reset masks the combinational accept.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (state == S_IDLE && win_found && !reset) req_ready[win_idx] = 1'b1;
        if (state == S_RESP) begin
            rsp_valid[cur_idx] = 1'b1;
            rsp_data           = res_q;
            rsp_err            = err_q;
        end
    end

    assign busy         = (state != S_IDLE);
    assign mul_in_valid = (state == S_ISSUE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: queued requester stimulus, a behavioural
// multiplier with pulse / stale-level / never-done modes, a round-robin
// reference and a scoreboard monitor checking every cycle.
module tb_mul_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int TO = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [2*W-1:0]   rsp_data;
    logic             rsp_err, busy;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_in_valid;
    logic [2*W-1:0]   mul_result;
    logic             mul_done;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    // mode: 0 = done pulse, 1 = done level (held until next op), 2 = never done
    typedef struct { int idx; logic [W-1:0] a; logic [W-1:0] b; int mode; int delay; } op_t;
    typedef struct { int idx; logic [2*W-1:0] data; logic err; } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    op_t  pend[$];
    op_t  cur_op[N];
    exp_t sb[$];
    int   grant_log[$];
    logic [N-1:0] acc_last = '0;
    int   cancel_idx = -1;
    bit   mbusy = 1'b0;
    int   cur_mode = 0;
    int   cur_delay = 2;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: hold valid until accepted, reload back-to-back from the queue.
    initial begin
        int  k;
        bit  cancel_on;
        cancel_on = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        forever begin
            @(posedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc_last[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && !(cancel_on && i == cancel_idx)) begin
                    k = -1;
                    for (int j = 0; j < pend.size(); j++)
                        if (k < 0 && pend[j].idx == i) k = j;
                    if (k >= 0) begin
                        cur_op[i] = pend[k];
                        pend.delete(k);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            if (cancel_on) begin
                req_valid[cancel_idx] = 1'b0;
                cancel_on = 1'b0;
                cancel_idx = -1;
            end else if (cancel_idx >= 0 && !req_valid[cancel_idx]) begin
                cur_op[cancel_idx].idx = cancel_idx;
                cur_op[cancel_idx].a = W'($urandom);
                cur_op[cancel_idx].b = W'($urandom);
                cur_op[cancel_idx].mode = 0;
                cur_op[cancel_idx].delay = 2;
                req_valid[cancel_idx] = 1'b1;
                cancel_on = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    req_a[i*W +: W] = cur_op[i].a;
                    req_b[i*W +: W] = cur_op[i].b;
                end else begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end
            end
        end
    end

    // Behavioural multiplier: done rises 'delay' cycles after the start strobe.
    initial begin
        int mk;
        int m_mode;
        logic [2*W-1:0] m_prod;
        mk = 0;
        m_mode = 0;
        m_prod = '0;
        mul_done = 1'b0;
        mul_result = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                mk = 0;
                mul_done = 1'b0;
            end else if (mul_in_valid) begin
                m_mode = cur_mode;
                mk = (cur_mode == 2) ? 0 : cur_delay;
                m_prod = (2*W)'(mul_a) * (2*W)'(mul_b);
                if (m_mode != 1) mul_done = 1'b0;
            end else begin
                if (mul_done && m_mode == 0) mul_done = 1'b0;
                if (mk > 0) begin
                    mk--;
                    if (mk == 1 && m_mode == 1) mul_done = 1'b0;
                    if (mk == 0) begin
                        mul_done = 1'b1;
                        mul_result = m_prod;
                    end
                end
            end
            if (!mul_done) mul_result = (2*W)'($urandom);
        end
    end

    // Monitor: reference arbitration, issue timing, scoreboard on responses.
    int           m_last = N - 1;
    int           m_w;
    int           acc_cyc = 0;
    int           exp_rsp_cyc = 0;
    logic [W-1:0] ea, eb;
    logic [N-1:0] exp_rdy, onehot;
    exp_t         e;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            mbusy = 1'b0;
            m_last = N - 1;
            acc_last = '0;
        end else begin
            chk(busy == mbusy, "busy", busy, mbusy);
            exp_rdy = '0;
            m_w = -1;
            if (!mbusy) m_w = rr_pick(req_valid, m_last);
            if (m_w >= 0) exp_rdy[m_w] = 1'b1;
            chk(req_ready == exp_rdy, "req_ready", req_ready, exp_rdy);
            acc_last = req_valid & req_ready;
            if (m_w >= 0) begin
                e.idx = m_w;
                e.err = (cur_op[m_w].mode == 2);
                e.data = e.err ? '0 : (2*W)'(cur_op[m_w].a) * (2*W)'(cur_op[m_w].b);
                sb.push_back(e);
                grant_log.push_back(m_w);
                acc_cyc = cyc;
                ea = cur_op[m_w].a;
                eb = cur_op[m_w].b;
                cur_mode = cur_op[m_w].mode;
                cur_delay = cur_op[m_w].delay;
                mbusy = 1'b1;
            end
            if (mul_in_valid) begin
                chk(cyc == acc_cyc + 1, "issue_latency", cyc - acc_cyc, 1);
                chk(mul_a == ea, "mul_a", mul_a, ea);
                chk(mul_b == eb, "mul_b", mul_b, eb);
                exp_rsp_cyc = cyc + ((cur_mode == 2) ? TO : cur_delay) + 1;
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    onehot = '0;
                    onehot[e.idx] = 1'b1;
                    chk(rsp_valid == onehot, "rsp_valid", rsp_valid, onehot);
                    chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
                    chk(rsp_err == e.err, "rsp_err", rsp_err, e.err);
                    chk(cyc == exp_rsp_cyc, "rsp_latency", cyc, exp_rsp_cyc);
                    m_last = e.idx;
                end
                mbusy = 1'b0;
            end else begin
                chk(rsp_data == '0 && rsp_err == 1'b0, "rsp_idle_zero", {rsp_err, rsp_data}, 0);
            end
        end
    end

    task automatic add_op(input int idx, input int a, input int b, input int mode, input int delay);
        op_t o;
        o.idx = idx;
        o.a = W'(a);
        o.b = W'(b);
        o.mode = mode;
        o.delay = delay;
        pend.push_back(o);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n;
        bit  idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < budget) begin
            @(negedge clk);
            n++;
            idle = (pend.size() == 0) && (req_valid == '0) && !mbusy && !busy;
        end
        chk(idle, {"idle_", name}, n, budget);
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic check_zero_outputs(input string name);
        @(negedge clk);
        chk(busy == 1'b0, {name, "_busy"}, busy, 0);
        chk(rsp_valid == '0, {name, "_rsp_valid"}, rsp_valid, 0);
        chk(rsp_data == '0, {name, "_rsp_data"}, rsp_data, 0);
        chk(rsp_err == 1'b0, {name, "_rsp_err"}, rsp_err, 0);
        chk(mul_in_valid == 1'b0, {name, "_mul_in_valid"}, mul_in_valid, 0);
        chk(mul_a == '0 && mul_b == '0, {name, "_mul_ops"}, {mul_a, mul_b}, 0);
        chk(req_ready == '0, {name, "_req_ready"}, req_ready, 0);
    endtask

    task automatic wait_issue(input string name);
        int n;
        n = 0;
        while (!mul_in_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(mul_in_valid, {"issue_seen_", name}, n, 50);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_zero_outputs("reset");

        // single requester: 9*6 on requester 1
        add_op(1, 9, 6, 0, 3);
        wait_idle(100, "single");

        // all four at once after reset: grants 0,1,2,3
        pulse_reset();
        base = grant_log.size();
        add_op(0, 15, 15, 0, 2);
        add_op(1, 3, 5, 0, 4);
        add_op(2, 7, 0, 0, 3);
        add_op(3, 2, 8, 0, 6);
        wait_idle(200, "all4");
        for (int i = 0; i < 4; i++)
            chk(grant_log.size() > base + i && grant_log[base + i] == i, "all4_order",
                (grant_log.size() > base + i) ? grant_log[base + i] : -1, i);

        // fairness: 0 and 2 held continuously -> 0,2,0,2,0,2
        base = grant_log.size();
        for (int i = 0; i < 3; i++) begin
            add_op(0, $urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom_range(2, 6));
            add_op(2, $urandom_range(0, 15), $urandom_range(0, 15), 0, $urandom_range(2, 6));
        end
        wait_idle(300, "fair");
        for (int i = 0; i < 6; i++)
            chk(grant_log.size() > base + i && grant_log[base + i] == ((i % 2) * 2), "fair_order",
                (grant_log.size() > base + i) ? grant_log[base + i] : -1, (i % 2) * 2);

        // stale level: done stays high from op 1, re-pulsed 5 cycles after op 2 issue;
        // a one-cycle request from 3 while busy must be forgotten
        add_op(0, 5, 7, 1, 3);
        wait_idle(100, "level1");
        add_op(1, 11, 13, 1, 5);
        wait_issue("stale");
        cancel_idx = 3;
        wait_idle(100, "stale");

        // timeout on requester 2, then requester 3 served normally
        add_op(2, 6, 7, 2, 0);
        add_op(3, 4, 4, 0, 3);
        wait_idle(200, "timeout");

        // reset mid-WAIT drops the op; then 0 beats 3
        add_op(1, 12, 12, 0, 10);
        wait_issue("rst");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_zero_outputs("midreset");
        base = grant_log.size();
        add_op(3, 3, 3, 0, 2);
        add_op(0, 13, 11, 0, 2);
        wait_idle(100, "post_rst");
        chk(grant_log.size() == base + 2 && grant_log[base] == 0 && grant_log[base + 1] == 3,
            "post_rst_order", (grant_log.size() > base) ? grant_log[base] : -1, 0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            add_op($urandom_range(0, N - 1), $urandom_range(0, 15), $urandom_range(0, 15),
                   ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1), $urandom_range(2, 8));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_idle(5000, "random");

        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
